// File: rtl/pipeline_stage_register.sv
// Parametrised valid/ready pipeline-stage register with optional skid entry,
// synchronous flush (ctrl forced to zero on bubbles) and a saturating stall counter.
module pipeline_stage_register #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [15:0]       stall_cnt;
  logic              main_valid;
  logic              skid_valid;
  logic              accept;
  logic              drain;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);

  // With SKID=1 in_ready is a pure decode of the state register, so the
  // backpressure path is cut; SKID=0 never reaches FULL because it refuses
  // a word unless main is empty or draining.
  assign in_ready = (SKID != 0) ? !skid_valid : (!main_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            state     <= HALF;
          end
        end
        HALF: begin
          if (drain && accept) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (drain) begin
            main_ctrl <= '0;
            state     <= EMPTY;
          end else if (accept) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            state     <= FULL;
          end
        end
        FULL: begin
          if (drain) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_ctrl <= '0;
            state     <= HALF;
          end
        end
        default: begin
          state     <= EMPTY;
          main_ctrl <= '0;
          skid_ctrl <= '0;
        end
      endcase
    end
  end

  // Performance counter survives flush; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign out_valid    = main_valid;
  assign out_data     = main_data;
  assign out_ctrl     = main_ctrl;
  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register: one SKID=1 and one SKID=0 instance, with a
// scoreboard queue per instance plus per-scenario directed checks.
module tb_pipeline_stage_register;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;

  logic clk;
  logic reset;

  logic              s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [DATA_W-1:0] s_in_data, s_out_data;
  logic [CTRL_W-1:0] s_in_ctrl, s_out_ctrl;
  logic [15:0]       s_stall;

  logic              n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [DATA_W-1:0] n_in_data, n_out_data;
  logic [CTRL_W-1:0] n_in_ctrl, n_out_ctrl;
  logic [15:0]       n_stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W+CTRL_W-1:0] sq[$];
  logic [DATA_W+CTRL_W-1:0] nq[$];
  logic [DATA_W+CTRL_W-1:0] s_exp, n_exp;
  logic [15:0]              stall_model;

  pipeline_stage_register #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) u_skid (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .stall_cycles(s_stall)
  );

  pipeline_stage_register #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) u_noskid (
    .clk(clk), .reset(reset), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_ctrl(n_in_ctrl),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
    .stall_cycles(n_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: inputs are stable at the falling edge, so handshakes seen here
  // are the ones the next rising edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      sq.delete();
      nq.delete();
      stall_model = 16'h0;
    end else begin
      if (s_out_valid && s_out_ready) begin
        n_checks++;
        if (sq.size() == 0) begin
          $display("FAIL skid_sb_extra: got data %0h ctrl %0h, required no word", s_out_data, s_out_ctrl);
          n_fail++;
        end else begin
          s_exp = sq.pop_front();
          if ({s_out_data, s_out_ctrl} !== s_exp) begin
            $display("FAIL skid_sb_word: got %0h/%0h, required %0h/%0h", s_out_data, s_out_ctrl,
                     s_exp[DATA_W+CTRL_W-1:CTRL_W], s_exp[CTRL_W-1:0]);
            n_fail++;
          end
        end
      end
      if (!s_out_valid) begin
        n_checks++;
        if (s_out_ctrl !== '0) begin
          $display("FAIL skid_bubble_ctrl: got %0h, required 0", s_out_ctrl);
          n_fail++;
        end
      end
      if (s_flush) sq.delete();
      else if (s_in_valid && s_in_ready) sq.push_back({s_in_data, s_in_ctrl});

      if (n_out_valid && n_out_ready) begin
        n_checks++;
        if (nq.size() == 0) begin
          $display("FAIL noskid_sb_extra: got data %0h ctrl %0h, required no word", n_out_data, n_out_ctrl);
          n_fail++;
        end else begin
          n_exp = nq.pop_front();
          if ({n_out_data, n_out_ctrl} !== n_exp) begin
            $display("FAIL noskid_sb_word: got %0h/%0h, required %0h/%0h", n_out_data, n_out_ctrl,
                     n_exp[DATA_W+CTRL_W-1:CTRL_W], n_exp[CTRL_W-1:0]);
            n_fail++;
          end
        end
      end
      if (n_flush) nq.delete();
      else if (n_in_valid && n_in_ready) nq.push_back({n_in_data, n_in_ctrl});

      if (s_out_valid && !s_out_ready && stall_model != 16'hFFFF) stall_model = stall_model + 16'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_flush = 0; s_in_valid = 0; s_in_data = '0; s_in_ctrl = '0; s_out_ready = 0;
    n_flush = 0; n_in_valid = 0; n_in_data = '0; n_in_ctrl = '0; n_out_ready = 0;
    step();
    step();
    n_checks++;
    if (s_out_valid !== 1'b0 || s_out_ctrl !== '0 || s_out_data !== '0) begin
      $display("FAIL reset_skid_out: got v=%0b d=%0h c=%0h, required 0/0/0", s_out_valid, s_out_data, s_out_ctrl);
      n_fail++;
    end
    n_checks++;
    if (s_stall !== 16'h0) begin
      $display("FAIL reset_stall: got %0h, required 0", s_stall);
      n_fail++;
    end
    n_checks++;
    if (s_in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got skid=%0b noskid=%0b, required 1/1", s_in_ready, n_in_ready);
      n_fail++;
    end
    n_checks++;
    if (n_out_valid !== 1'b0 || n_out_ctrl !== '0 || n_out_data !== '0) begin
      $display("FAIL reset_noskid_out: got v=%0b d=%0h c=%0h, required 0/0/0", n_out_valid, n_out_data, n_out_ctrl);
      n_fail++;
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
    s_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      s_in_valid = 1; s_in_data = vals[i]; s_in_ctrl = 8'h05;
      n_checks++;
      if (s_in_ready !== 1'b1) begin
        $display("FAIL stream_in_ready[%0d]: got %0b, required 1", i, s_in_ready);
        n_fail++;
      end
      step();
      n_checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== vals[i] || s_out_ctrl !== 8'h05) begin
        $display("FAIL stream_out[%0d]: got v=%0b d=%0h c=%0h, required 1/%0h/05", i, s_out_valid, s_out_data, s_out_ctrl, vals[i]);
        n_fail++;
      end
    end
    s_in_valid = 0;
    step();
    n_checks++;
    if (s_out_valid !== 1'b0 || s_out_ctrl !== '0) begin
      $display("FAIL stream_drained: got v=%0b c=%0h, required 0/0", s_out_valid, s_out_ctrl);
      n_fail++;
    end
  endtask

  task automatic test_backpressure();
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'hA; s_in_ctrl = 8'h01;
    step();
    n_checks++;
    if (s_in_ready !== 1'b1) begin
      $display("FAIL bp_ready_after_a: got %0b, required 1", s_in_ready);
      n_fail++;
    end
    s_in_data = 64'hB; s_in_ctrl = 8'h02;
    step();
    n_checks++;
    if (s_in_ready !== 1'b0) begin
      $display("FAIL bp_ready_full: got %0b, required 0", s_in_ready);
      n_fail++;
    end
    s_in_data = 64'hC; s_in_ctrl = 8'h03;
    step();
    n_checks++;
    if (s_in_ready !== 1'b0 || s_out_data !== 64'hA) begin
      $display("FAIL bp_hold: got rdy=%0b d=%0h, required 0/a", s_in_ready, s_out_data);
      n_fail++;
    end
    s_out_ready = 1;
    step();
    n_checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 64'hB || s_in_ready !== 1'b1) begin
      $display("FAIL bp_drain_b: got v=%0b d=%0h rdy=%0b, required 1/b/1", s_out_valid, s_out_data, s_in_ready);
      n_fail++;
    end
    step();
    n_checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 64'hC) begin
      $display("FAIL bp_drain_c: got v=%0b d=%0h, required 1/c", s_out_valid, s_out_data);
      n_fail++;
    end
    s_in_valid = 0;
    step();
    n_checks++;
    if (s_out_valid !== 1'b0) begin
      $display("FAIL bp_empty: got %0b, required 0", s_out_valid);
      n_fail++;
    end
  endtask

  task automatic test_flush();
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'h1; s_in_ctrl = 8'h11;
    step();
    s_in_data = 64'h2; s_in_ctrl = 8'h12;
    step();
    s_flush = 1; s_in_valid = 1; s_in_data = 64'hD; s_in_ctrl = 8'hFF;
    step();
    s_flush = 0; s_in_valid = 0;
    n_checks++;
    if (s_out_valid !== 1'b0 || s_out_ctrl !== '0 || s_in_ready !== 1'b1) begin
      $display("FAIL flush_full: got v=%0b c=%0h rdy=%0b, required 0/0/1", s_out_valid, s_out_ctrl, s_in_ready);
      n_fail++;
    end
    s_in_valid = 1; s_in_data = 64'h3; s_in_ctrl = 8'h13;
    step();
    s_flush = 1; s_in_data = 64'hE; s_in_ctrl = 8'hFE;
    step();
    s_flush = 0; s_in_valid = 0;
    n_checks++;
    if (s_out_valid !== 1'b0 || s_out_ctrl !== '0) begin
      $display("FAIL flush_half_accept: got v=%0b c=%0h, required 0/0", s_out_valid, s_out_ctrl);
      n_fail++;
    end
    s_in_valid = 1; s_in_data = 64'h44; s_in_ctrl = 8'h14; s_out_ready = 1;
    step();
    s_in_valid = 0;
    n_checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 64'h44 || s_out_ctrl !== 8'h14) begin
      $display("FAIL flush_next_word: got v=%0b d=%0h c=%0h, required 1/44/14", s_out_valid, s_out_data, s_out_ctrl);
      n_fail++;
    end
    step();
  endtask

  task automatic test_noskid();
    n_out_ready = 1;
    n_in_valid = 1; n_in_data = 64'h61; n_in_ctrl = 8'h21;
    step();
    n_checks++;
    if (n_out_valid !== 1'b1 || n_out_data !== 64'h61) begin
      $display("FAIL noskid_first: got v=%0b d=%0h, required 1/61", n_out_valid, n_out_data);
      n_fail++;
    end
    n_in_data = 64'h62; n_in_ctrl = 8'h22;
    #1;
    n_checks++;
    if (n_in_ready !== 1'b1) begin
      $display("FAIL noskid_ready_drain: got %0b, required 1", n_in_ready);
      n_fail++;
    end
    step();
    n_checks++;
    if (n_out_data !== 64'h62 || n_out_ctrl !== 8'h22) begin
      $display("FAIL noskid_second: got d=%0h c=%0h, required 62/22", n_out_data, n_out_ctrl);
      n_fail++;
    end
    n_out_ready = 0; n_in_data = 64'h63; n_in_ctrl = 8'h23;
    #1;
    n_checks++;
    if (n_in_ready !== 1'b0) begin
      $display("FAIL noskid_ready_stall: got %0b, required 0", n_in_ready);
      n_fail++;
    end
    step();
    n_checks++;
    if (n_out_data !== 64'h62) begin
      $display("FAIL noskid_hold: got %0h, required 62", n_out_data);
      n_fail++;
    end
    n_out_ready = 1;
    step();
    n_in_valid = 0;
    n_checks++;
    if (n_out_data !== 64'h63 || n_out_valid !== 1'b1) begin
      $display("FAIL noskid_third: got v=%0b d=%0h, required 1/63", n_out_valid, n_out_data);
      n_fail++;
    end
    step();
    n_checks++;
    if (n_out_valid !== 1'b0 || n_out_ctrl !== '0) begin
      $display("FAIL noskid_empty: got v=%0b c=%0h, required 0/0", n_out_valid, n_out_ctrl);
      n_fail++;
    end
  endtask

  task automatic test_stall();
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'h55; s_in_ctrl = 8'h31;
    step();
    s_in_valid = 0;
    n_checks++;
    if (s_stall !== stall_model) begin
      $display("FAIL stall_count: got %0h, required %0h", s_stall, stall_model);
      n_fail++;
    end
    repeat (65540) @(posedge clk);
    #1;
    n_checks++;
    if (s_stall !== 16'hFFFF || s_out_valid !== 1'b1) begin
      $display("FAIL stall_saturate: got cnt=%0h v=%0b, required ffff/1", s_stall, s_out_valid);
      n_fail++;
    end
    s_flush = 1;
    step();
    s_flush = 0;
    n_checks++;
    if (s_stall !== 16'hFFFF || s_out_valid !== 1'b0) begin
      $display("FAIL stall_after_flush: got cnt=%0h v=%0b, required ffff/0", s_stall, s_out_valid);
      n_fail++;
    end
    reset = 1;
    #1;
    n_checks++;
    if (s_stall !== 16'h0) begin
      $display("FAIL stall_after_reset: got %0h, required 0", s_stall);
      n_fail++;
    end
    step();
    reset = 0;
    step();
  endtask

  task automatic test_async_reset();
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'h71; s_in_ctrl = 8'h41;
    step();
    s_in_data = 64'h72; s_in_ctrl = 8'h42;
    step();
    s_in_valid = 0;
    n_checks++;
    if (s_in_ready !== 1'b0 || s_out_data !== 64'h71) begin
      $display("FAIL areset_setup: got rdy=%0b d=%0h, required 0/71", s_in_ready, s_out_data);
      n_fail++;
    end
    #2;
    reset = 1;
    #1;
    n_checks++;
    if (s_out_valid !== 1'b0 || s_out_ctrl !== '0 || s_out_data !== '0 || s_in_ready !== 1'b1) begin
      $display("FAIL areset_mid_cycle: got v=%0b c=%0h d=%0h rdy=%0b, required 0/0/0/1",
               s_out_valid, s_out_ctrl, s_out_data, s_in_ready);
      n_fail++;
    end
    step();
    reset = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_noskid();
    test_stall();
    test_async_reset();
    n_checks++;
    if (sq.size() != 0 || nq.size() != 0) begin
      $display("FAIL sb_leftover: got skid=%0d noskid=%0d words, required 0/0", sq.size(), nq.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
